// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Definitions shared across the RV32 pipeline: data width,
//               the bubble instruction word, the default reset PC and the
//               next-PC select encoding (also used by the hazard unit).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_TARGET = 1'b1
    } pcsel_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Generic pipeline register. Asynchronous reset and
//               synchronous clear both load RESET_VAL; clear has priority
//               over the enable. Reused for every pipeline boundary.
// Ports       : clk, reset (async, active-high), clear (sync bubble load),
//               en (capture d when high), d (input word), q (registered word)
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // A clear must beat a stall, so it is evaluated ahead of the enable.
    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = RESET_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32 instruction-fetch stage. Holds the PC, selects the
//               sequential or redirected next PC, addresses instruction
//               memory and captures the fetched word into IF/ID.
// Ports       : clk, reset (async, active-high)
//               stall_f / stall_d / flush_d   - hazard-unit controls
//               pcsrc_e, pctarget_e           - redirect from EX
//               imem_addr -> / imem_rdata <-  - combinational instr memory
//               pc_f                          - current fetch PC
//               instr_d, pc_d, pcplus4_d, valid_d - IF/ID register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::XLEN;
    import riscv_pkg::pcsel_t;
    import riscv_pkg::PC_PLUS4;
    import riscv_pkg::PC_TARGET;
#(
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pctarget_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d,
    output logic            valid_d
);

    localparam int               IFID_W = 1 + 3 * XLEN;
    // Bubble: not valid, zero PCs, NOP instruction.
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, {XLEN{1'b0}}, {XLEN{1'b0}}, NOP_INSTR};

    logic [XLEN-1:0]   pcf_q;
    logic [XLEN-1:0]   pcf_d;
    logic [XLEN-1:0]   pcplus4_f;
    logic [XLEN-1:0]   target_aligned;
    pcsel_t            pcsel;
    logic [IFID_W-1:0] ifid_in;
    logic [IFID_W-1:0] ifid_out;

    // Wraps naturally modulo 2^32.
    assign pcplus4_f      = pcf_q + 32'd4;
    // Instructions are word aligned; the low target bits are discarded.
    assign target_aligned = pctarget_e & ~32'h0000_0003;

    // A redirect wins over a fetch stall: the stalled instruction is on the
    // wrong path anyway.
    always_comb begin
        pcsel = pcsrc_e ? PC_TARGET : PC_PLUS4;
        pcf_d = pcf_q;
        case (pcsel)
            PC_TARGET: pcf_d = target_aligned;
            default:   pcf_d = stall_f ? pcf_q : pcplus4_f;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf_q <= RESET_PC;
        end else begin
            pcf_q <= pcf_d;
        end
    end

    assign pc_f      = pcf_q;
    assign imem_addr = pcf_q;

    assign ifid_in = {1'b1, pcplus4_f, pcf_q, imem_rdata};

    if_id_reg #(
        .WIDTH     (IFID_W),
        .RESET_VAL (IFID_BUBBLE)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .clear (flush_d),
        .en    (~stall_d),
        .d     (ifid_in),
        .q     (ifid_out)
    );

    assign {valid_d, pcplus4_d, pc_d, instr_d} = ifid_out;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural model of
//               the fetch PC and IF/ID contents is advanced every clock from
//               the same inputs the DUT sees and compared after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pcp4d;
    logic        m_valid;

    fetch_stage #(
        .RESET_PC  (C_RESET_PC),
        .NOP_INSTR (C_NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .pcsrc_e    (pcsrc_e),
        .pctarget_e (pctarget_e),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .pc_f       (pc_f),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 | addr;
    endfunction

    // Combinational instruction memory
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = C_RESET_PC;
        m_instr = C_NOP;
        m_pcd   = 32'd0;
        m_pcp4d = 32'd0;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc_f"},      pc_f,      m_pc);
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".instr_d"},   instr_d,   m_instr);
        check({tag, ".pc_d"},      pc_d,      m_pcd);
        check({tag, ".pcplus4_d"}, pcplus4_d, m_pcp4d);
        check({tag, ".valid_d"},   {31'd0, valid_d}, {31'd0, m_valid});
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, then
    // compare shortly after the edge.
    task automatic cycle(input string tag, input logic sf, input logic sd,
                         input logic fl, input logic src, input logic [31:0] tgt);
        logic [31:0] old_pc;
        stall_f    = sf;
        stall_d    = sd;
        flush_d    = fl;
        pcsrc_e    = src;
        pctarget_e = tgt;
        @(posedge clk);
        old_pc = m_pc;
        if (src)      m_pc = {tgt[31:2], 2'b00};
        else if (!sf) m_pc = old_pc + 32'd4;
        if (fl) begin
            m_instr = C_NOP; m_pcd = 32'd0; m_pcp4d = 32'd0; m_valid = 1'b0;
        end else if (!sd) begin
            m_instr = mem_word(old_pc); m_pcd = old_pc;
            m_pcp4d = old_pc + 32'd4;   m_valid = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; pctarget_e = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Free run: pc 0 -> 4 -> 8
        run("free1");
        run("free2");
        check("free.instr_at4", instr_d, 32'h1000_0004);

        // Redirect at pc_f = 8 to 0x102 (aligned to 0x100) with flush
        cycle("redir", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0102);
        check("redir.pc", pc_f, 32'h0000_0100);
        run("redir_next");
        check("redir.instr", instr_d, 32'h1000_0100);

        // Reach pc_f = 0x0C, then a two-cycle load-use stall
        cycle("to8", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0008);
        run("toC");
        check("ldu.pre_instr", instr_d, 32'h1000_0008);
        cycle("ldu1", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        cycle("ldu2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        check("ldu.hold_pc", pc_f, 32'h0000_000C);
        run("ldu_rel");
        check("ldu.after", instr_d, 32'h1000_000C);

        // Redirect beats stall_f; flush beats stall_d
        cycle("stall_vs_redir", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        check("svr.pc", pc_f, 32'h0000_0040);
        cycle("flush_vs_stall", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check("fvs.valid", {31'd0, valid_d}, 32'd0);

        // Wrap-around
        cycle("wrap_redir", 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        run("wrap1");
        check("wrap.pc", pc_f, 32'd0);
        check("wrap.p4d", pcplus4_d, 32'd0);

        // Mid-run asynchronous reset at pc_f = 0x20
        cycle("to20", 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0020);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        run("resume1");
        check("resume.instr", instr_d, 32'h1000_0000);
        run("resume2");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_sf, r_sd, r_fl, r_src;
            logic [31:0] r_tgt;
            r_sf  = ($urandom_range(0, 3) == 0);
            r_sd  = r_sf ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            r_src = ($urandom_range(0, 7) == 0);
            r_fl  = r_src ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            r_tgt = $urandom();
            cycle("rand", r_sf, r_sd, r_fl, r_src, r_tgt);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit pipelined RISC-V core. Holds the program counter and computes the sequential/redirected next PC. Drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register. Its `instr_d[31:7]` field feeds the decode-stage immediate extender directly. Supports hazard-unit stall/flush and branch/jump redirects resolved in EX.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): bubble word placed in IF/ID on reset or flush.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `stall_f`: input, 1 bit. Holds the PC.
- `stall_d`: input, 1 bit. Holds the IF/ID register.
- `flush_d`: input, 1 bit. Loads a bubble into IF/ID.
- `pcsrc_e`: input, 1 bit. Redirect request from EX (taken branch or jump).
- `pctarget_e`: input, 32 bits. Redirect target from EX.
- `imem_addr`: output, 32 bits. Instruction-memory address; equals `pc_f`.
- `imem_rdata`: input, 32 bits. Instruction word. Combinational read of `imem_addr`, valid in the same cycle.
- `pc_f`: output, 32 bits. Current fetch PC.
- `instr_d`: output, 32 bits. Registered instruction for decode.
- `pc_d`: output, 32 bits. PC of `instr_d`.
- `pcplus4_d`: output, 32 bits. `pc_d + 4`.
- `valid_d`: output, 1 bit. `instr_d` is a real fetched instruction, not a bubble.

## Operation
- `pcplus4_f = pc_f + 4`, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Next-PC select: if `pcsrc_e`, next PC is `{pctarget_e[31:2], 2'b00}`; otherwise it is `pcplus4_f`. The low two bits of the target are always cleared.
- PC register update, in priority order:
  1. `reset` loads `RESET_PC`.
  2. `pcsrc_e` loads the target. The redirect wins over `stall_f`.
  3. `stall_f` holds the PC.
  4. Otherwise the PC loads `pcplus4_f`.
- IF/ID register update, in priority order:
  1. `reset` loads `instr_d = NOP_INSTR`, `pc_d = 0`, `pcplus4_d = 0`, `valid_d = 0`.
  2. `flush_d` loads the same bubble values as reset.
  3. `stall_d` holds all four fields.
  4. Otherwise it loads `imem_rdata`, `pc_f`, `pcplus4_f`, and sets `valid_d = 1`.
- `flush_d` together with `stall_d`: flush wins.
- `pcsrc_e` does not itself flush IF/ID. The hazard unit asserts `flush_d` in the same cycle.
- `reset` asserted mid-operation clears the PC and IF/ID immediately, independent of the clock. The first fetch after deassertion is at `RESET_PC`.

## Timing
- Reset values:
  - `pc_f` = `imem_addr` = `RESET_PC`.
  - `instr_d` = `NOP_INSTR`.
  - `pc_d` = 0, `pcplus4_d` = 0, `valid_d` = 0.
- Fetch-to-decode latency is 1 cycle. The word at `pc_f` in cycle N appears on `instr_d` in cycle N+1.
- Redirect: with `pcsrc_e` high in cycle N, `pc_f` equals the target in cycle N+1, and the target instruction reaches `instr_d` in cycle N+2.
- Stall: every cycle `stall_f` and `stall_d` are both high, `pc_f` and `instr_d` stay bit-identical. No fetch is lost or duplicated when the stall releases.
- No combinational path from any input to `pc_f`, `instr_d`, `pc_d`, `pcplus4_d`, or `valid_d`. `imem_addr` is a pure wire from `pc_f`.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN = 32`
  - `NOP_INSTR` constant
  - `RESET_PC` default
  - `pcsel_t` enum (`PC_PLUS4`, `PC_TARGET`), reused by the hazard unit
- One sub-module, `if_id_reg`: a parameterised-width register with async reset, synchronous clear (flush) and enable (not stall). It resets and clears to a parameterised value. The same module is reused for the later ID/EX, EX/MEM and MEM/WB registers.
- The PC register, `+4` adder and next-PC mux live in `fetch_stage` itself.

## Test plan
- **Reset then free run.** Assert reset, release it, no stalls, memory returns `0x1000_0000 | addr` → `pc_f` steps 0, 4, 8. One cycle later `instr_d` reads 0x1000_0000, 0x1000_0004, … with `valid_d` = 1 and `pcplus4_d` = `pc_d + 4`.
- **Redirect.** `pcsrc_e` = 1, `pctarget_e` = 32'h0000_0102, `flush_d` = 1 at `pc_f` = 8 → next `pc_f` = 0x100. `instr_d` = 0x0000_0013 with `valid_d` = 0 for one cycle, then `instr_d` = 0x1000_0100.
- **Load-use stall.** `stall_f` = `stall_d` = 1 for 2 cycles at `pc_f` = 0x0C → `pc_f` holds 0x0C and `instr_d` holds 0x1000_0008. After release, `instr_d` = 0x1000_000C with no gap or repeat.
- **Simultaneous events.** `stall_f` = 1 and `pcsrc_e` = 1 with target 0x40 → `pc_f` = 0x40. Separately, `flush_d` = 1 with `stall_d` = 1 → bubble loaded.
- **Wrap-around.** Redirect to 0xFFFF_FFFC → the following `pc_f` = 0, and `pcplus4_d` for that fetch = 0.
- **Reset mid-run.** Assert reset between clock edges at `pc_f` = 0x20 → `pc_f` = 0 and `instr_d` = NOP before the next edge. Fetch resumes at 0 after release.
